// File: rtl/bias_add_ctrl_pkg.sv
// Shared state encoding, lane geometry and default widths for the bias-add sequencer.
package npu_bias_pkg;
   localparam int NPE_LANES  = 32;
   localparam int LANE_W     = 16;
   localparam int NPE_DAT_W  = NPE_LANES * LANE_W;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/bias_add_ctrl_if.sv
// Handshake/config/adder bundle of the bias-add sequencer; master = sequencer, slave = its environment.
interface bias_add_ctrl_if import npu_bias_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
);
   logic                 i_start;
   logic [ADDR_W-1:0]    i_cfg_base;
   logic [ADDR_W-1:0]    i_cfg_bias_len;
   logic [CNT_W-1:0]     i_cfg_vec_num;
   logic                 i_npe_vld;
   logic                 o_npe_rdy;
   logic [NPE_DAT_W-1:0] i_npe_dat;
   logic                 o_ram_rd_en;
   logic [ADDR_W-1:0]    o_ram_addr;
   logic                 o_add_en;
   logic [NPE_DAT_W-1:0] o_add_npe_dat;
   logic                 o_out_vld;
   logic                 i_out_rdy;
   logic                 o_busy;
   logic                 o_done;

   modport master (
      input  i_start, i_cfg_base, i_cfg_bias_len, i_cfg_vec_num,
      input  i_npe_vld, i_npe_dat, i_out_rdy,
      output o_npe_rdy, o_ram_rd_en, o_ram_addr, o_add_en, o_add_npe_dat,
      output o_out_vld, o_busy, o_done
   );

   modport slave (
      output i_start, i_cfg_base, i_cfg_bias_len, i_cfg_vec_num,
      output i_npe_vld, i_npe_dat, i_out_rdy,
      input  o_npe_rdy, o_ram_rd_en, o_ram_addr, o_add_en, o_add_npe_dat,
      input  o_out_vld, o_busy, o_done
   );
endinterface

// File: rtl/bias_add_ctrl_addr_gen.sv
// Bias RAM address generator: base + bias index, index wrapping modulo bias_len (0 acts as 1).
module bias_addr_gen import npu_bias_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_len,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr
);
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] len_r;
   logic [ADDR_W-1:0] bidx_r;
   logic [ADDR_W-1:0] last_s;

   // last valid bias index of the pattern
   always_comb begin
      if (len_r == ADDR_W'(0)) begin
         last_s = ADDR_W'(0);
      end else begin
         last_s = len_r - ADDR_W'(1);
      end
   end

   // config latch and wrapping bias index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_r <= ADDR_W'(0);
         len_r  <= ADDR_W'(0);
         bidx_r <= ADDR_W'(0);
      end else if (load) begin
         base_r <= cfg_base;
         len_r  <= cfg_len;
         bidx_r <= ADDR_W'(0);
      end else if (advance) begin
         bidx_r <= (bidx_r == last_s) ? ADDR_W'(0) : bidx_r + ADDR_W'(1);
      end else begin
         bidx_r <= bidx_r;
      end
   end

   // the sum wraps past 2^ADDR_W on its own
   assign addr = base_r + bidx_r;
endmodule

// File: rtl/bias_add_ctrl.sv
// Bias-add sequencer: accepts NPE vectors, issues bias RAM reads, aligns data to the adder.
// Optional stall-cycle counter port o_stall_cnt when BIAS_ADD_CTRL_PERF_EN is defined.
module bias_add_ctrl import npu_bias_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic            i_clk,
   input  logic            i_rst,
   bias_add_ctrl_if.master bus
`ifdef BIAS_ADD_CTRL_PERF_EN
   ,
   output logic [31:0]     o_stall_cnt
`endif
);
   state_e               state_r;
   state_e               state_nxt_s;
   logic [CNT_W-1:0]     vcnt_r;
   logic [CNT_W-1:0]     vec_num_r;
   logic [CNT_W-1:0]     vcnt_inc_s;
   logic                 s2_vld_r;
   logic [NPE_DAT_W-1:0] s2_dat_r;
   logic                 out_vld_r;
   logic                 stall_s;
   logic                 start_s;
   logic                 room_s;
   logic                 accept_s;
   logic                 empty_s;
   logic                 busy_s;
   logic [ADDR_W-1:0]    addr_s;

   // handshake decode and next-state logic
   always_comb begin
      stall_s     = out_vld_r & ~bus.i_out_rdy;
      start_s     = (state_r == ST_IDLE) & bus.i_start;
      room_s      = (vcnt_r != vec_num_r);
      vcnt_inc_s  = vcnt_r + CNT_W'(1);
      accept_s    = (state_r == ST_RUN) & room_s & ~stall_s & bus.i_npe_vld;
      empty_s     = ~s2_vld_r & ~out_vld_r;
      busy_s      = (state_r != ST_IDLE);
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) state_nxt_s = ST_RUN;
            else         state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (!room_s)                                   state_nxt_s = ST_DRAIN;
            else if (accept_s && (vcnt_inc_s == vec_num_r)) state_nxt_s = ST_DRAIN;
            else                                           state_nxt_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (empty_s) state_nxt_s = ST_IDLE;
            else         state_nxt_s = ST_DRAIN;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_r <= ST_IDLE;
      else       state_r <= state_nxt_s;
   end

   // job length latch and vector counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vcnt_r    <= CNT_W'(0);
         vec_num_r <= CNT_W'(0);
      end else if (start_s) begin
         vcnt_r    <= CNT_W'(0);
         vec_num_r <= bus.i_cfg_vec_num;
      end else if (accept_s) begin
         vcnt_r    <= vcnt_inc_s;
      end else begin
         vcnt_r    <= vcnt_r;
      end
   end

   // pipeline stages; everything freezes while the writer backpressures
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_vld_r  <= 1'b0;
         s2_dat_r  <= '0;
         out_vld_r <= 1'b0;
      end else if (!stall_s) begin
         s2_vld_r  <= accept_s;
         s2_dat_r  <= accept_s ? bus.i_npe_dat : s2_dat_r;
         out_vld_r <= s2_vld_r;
      end else begin
         s2_vld_r  <= s2_vld_r;
         s2_dat_r  <= s2_dat_r;
         out_vld_r <= out_vld_r;
      end
   end

   bias_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk      (i_clk),
      .rst      (i_rst),
      .load     (start_s),
      .cfg_base (bus.i_cfg_base),
      .cfg_len  (bus.i_cfg_bias_len),
      .advance  (accept_s),
      .addr     (addr_s)
   );

   assign bus.o_npe_rdy     = (state_r == ST_RUN) & room_s & ~stall_s;
   assign bus.o_ram_rd_en   = accept_s;
   assign bus.o_ram_addr    = addr_s;
   assign bus.o_add_en      = s2_vld_r & ~stall_s;
   assign bus.o_add_npe_dat = s2_dat_r;
   assign bus.o_out_vld     = out_vld_r;
   assign bus.o_busy        = busy_s;
   assign bus.o_done        = (state_r == ST_DRAIN) & empty_s;

`ifdef BIAS_ADD_CTRL_PERF_EN
   logic [31:0] stall_cnt_r;

   // saturating count of stalled cycles within a job
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                  stall_cnt_r <= 32'd0;
      else if (start_s)           stall_cnt_r <= 32'd0;
      else if (busy_s && stall_s) stall_cnt_r <= sat_inc32(stall_cnt_r);
      else                        stall_cnt_r <= stall_cnt_r;
   end

   assign o_stall_cnt = stall_cnt_r;
`endif
endmodule

// File: tb/tb_bias_add_ctrl.sv
// Directed self-checking bench for bias_add_ctrl (optionally built with BIAS_ADD_CTRL_PERF_EN).
module tb_bias_add_ctrl;
   import npu_bias_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bias_add_ctrl_if #(.ADDR_W(8), .CNT_W(16)) bus ();
`ifdef BIAS_ADD_CTRL_PERF_EN
   logic [31:0] stall_cnt;
`endif

   bias_add_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
`ifdef BIAS_ADD_CTRL_PERF_EN
      ,
      .o_stall_cnt (stall_cnt)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rd_n = 0;
   int vld_n = 0;
   int busy_n = 0;
   int job_tag = 0;
   int         acc_cyc_q [$];
   logic [8:0] acc_addr_q [$];
   int         add_cyc_q [$];
   logic [511:0] add_dat_q [$];
   int         ret_cyc_q [$];
   int         done_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   // event log sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.i_npe_vld && bus.o_npe_rdy) begin
            acc_cyc_q.push_back(cyc);
            acc_addr_q.push_back({bus.o_ram_rd_en, bus.o_ram_addr});
         end
         if (bus.o_ram_rd_en) rd_n <= rd_n + 1;
         if (bus.o_add_en) begin
            add_cyc_q.push_back(cyc);
            add_dat_q.push_back(bus.o_add_npe_dat);
         end
         if (bus.o_out_vld) vld_n <= vld_n + 1;
         if (bus.o_out_vld && bus.i_out_rdy) ret_cyc_q.push_back(cyc);
         if (bus.o_done) done_q.push_back(cyc);
         if (bus.o_busy) busy_n <= busy_n + 1;
      end
   end

   function automatic logic [511:0] mkvec(input int tag, input int k);
      logic [511:0] v;
      for (int l = 0; l < 32; l++) v[l*16 +: 16] = {tag[3:0], k[3:0], l[7:0]};
      return v;
   endfunction

   // runs one job; config inputs are scrambled after start to prove they were latched
   task automatic drive_job(input logic [7:0] base, input logic [7:0] len, input logic [15:0] num,
                            input int stall_n, input int restart_at,
                            output int s_cyc, output int d_cyc, output int st_seen, output int st_bad);
      int k;
      int stall_rem;
      bit acc;
      bit first_vld;
      bit done_flag;
      k = 0; stall_rem = 0; first_vld = 1'b0; done_flag = 1'b0;
      st_seen = 0; st_bad = 0; d_cyc = -1;
      bus.i_cfg_base = base; bus.i_cfg_bias_len = len; bus.i_cfg_vec_num = num;
      bus.i_start = 1'b1; bus.i_npe_vld = 1'b0; bus.i_out_rdy = 1'b1;
      s_cyc = cyc;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_cfg_base = 8'hA5; bus.i_cfg_bias_len = 8'h5A; bus.i_cfg_vec_num = 16'h0077;
      bus.i_npe_vld = (num != 16'd0);
      bus.i_npe_dat = mkvec(job_tag, 0);
      for (int c = 0; c < 300 && !done_flag; c++) begin
         @(negedge clk);
         acc = bus.i_npe_vld && bus.o_npe_rdy;
         if (!bus.i_out_rdy) begin
            st_seen++;
            if (bus.o_add_en || bus.o_ram_rd_en || bus.o_npe_rdy || !bus.o_out_vld) st_bad++;
         end
         if (bus.o_out_vld && !first_vld) begin
            first_vld = 1'b1;
            stall_rem = stall_n;
         end
         if (bus.o_done) begin
            done_flag = 1'b1;
            d_cyc = cyc;
         end
         @(posedge clk); #1;
         if (acc) k++;
         bus.i_npe_vld = (k < int'(num));
         bus.i_npe_dat = mkvec(job_tag, k);
         if (stall_rem > 0) begin
            bus.i_out_rdy = 1'b0;
            stall_rem--;
         end else begin
            bus.i_out_rdy = 1'b1;
         end
         bus.i_start = (restart_at > 0) && ((cyc - s_cyc) == restart_at);
      end
      bus.i_npe_vld = 1'b0; bus.i_start = 1'b0; bus.i_out_rdy = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.o_npe_rdy, bus.o_ram_rd_en, bus.o_add_en, bus.o_out_vld, bus.o_busy, bus.o_done} !== 6'b0) begin
         n_bad++;
         $display("FAIL rst_ctrl: got %b want 000000", {bus.o_npe_rdy, bus.o_ram_rd_en, bus.o_add_en, bus.o_out_vld, bus.o_busy, bus.o_done});
      end
      n_cmp++;
      if (bus.o_ram_addr !== 8'h00 || bus.o_add_npe_dat !== 512'd0) begin
         n_bad++;
         $display("FAIL rst_data: got addr %h dat_lo %h want 0", bus.o_ram_addr, bus.o_add_npe_dat[31:0]);
      end
`ifdef BIAS_ADD_CTRL_PERF_EN
      n_cmp++;
      if (stall_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.o_busy, bus.o_npe_rdy, bus.o_done} !== 3'b000) begin
         n_bad++;
         $display("FAIL rst_idle: got %b want 000", {bus.o_busy, bus.o_npe_rdy, bus.o_done});
      end
      @(posedge clk); #1;
   endtask

   // base 0x10, len 4, six vectors, no backpressure; restart_at>0 injects an illegal start
   task automatic test_basic(input int tag_v, input int restart_at, input string nm);
      int s, d, ss, sb, a0, d0, r0, dn0, rd0, b0;
      logic [8:0] exp_a [6];
      exp_a = '{9'h110, 9'h111, 9'h112, 9'h113, 9'h110, 9'h111};
      a0 = acc_cyc_q.size(); d0 = add_dat_q.size(); r0 = ret_cyc_q.size();
      dn0 = done_q.size(); rd0 = rd_n; b0 = busy_n;
      job_tag = tag_v;
      drive_job(8'h10, 8'h04, 16'd6, 0, restart_at, s, d, ss, sb);
      n_cmp++;
      if (d !== s + 9) begin n_bad++; $display("FAIL %s_done_cyc: got %0d want %0d", nm, d - s, 9); end
      n_cmp++;
      if (acc_cyc_q.size() - a0 !== 6) begin n_bad++; $display("FAIL %s_acc_cnt: got %0d want 6", nm, acc_cyc_q.size() - a0); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (acc_addr_q[a0+i] !== exp_a[i] || acc_cyc_q[a0+i] !== s + 1 + i) begin
            n_bad++;
            $display("FAIL %s_acc%0d: got rd/addr %h @%0d want %h @%0d", nm, i, acc_addr_q[a0+i], acc_cyc_q[a0+i] - s, exp_a[i], 1 + i);
         end
         n_cmp++;
         if (add_dat_q[d0+i] !== mkvec(tag_v, i)) begin
            n_bad++;
            $display("FAIL %s_add_dat%0d: got %h want %h", nm, i, add_dat_q[d0+i][31:0], mkvec(tag_v, i)[31:0]);
         end
         n_cmp++;
         if (ret_cyc_q[r0+i] !== s + 3 + i) begin
            n_bad++;
            $display("FAIL %s_out_vld%0d: got @%0d want @%0d", nm, i, ret_cyc_q[r0+i] - s, 3 + i);
         end
      end
      n_cmp++;
      if (rd_n - rd0 !== 6) begin n_bad++; $display("FAIL %s_rd_cnt: got %0d want 6", nm, rd_n - rd0); end
      n_cmp++;
      if (done_q.size() - dn0 !== 1) begin n_bad++; $display("FAIL %s_done_cnt: got %0d want 1", nm, done_q.size() - dn0); end
      n_cmp++;
      if (busy_n - b0 !== 9) begin n_bad++; $display("FAIL %s_busy_cycles: got %0d want 9", nm, busy_n - b0); end
`ifdef BIAS_ADD_CTRL_PERF_EN
      n_cmp++;
      if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL %s_stall_cnt: got %0d want 0", nm, stall_cnt); end
`endif
   endtask

   task automatic test_backpressure();
      int s, d, ss, sb, a0, d0, r0, v0;
      int exp_acc [6];
      int exp_add [6];
      int exp_ret [6];
      exp_acc = '{1, 2, 3, 9, 10, 11};
      exp_add = '{2, 3, 9, 10, 11, 12};
      exp_ret = '{3, 9, 10, 11, 12, 13};
      a0 = acc_cyc_q.size(); d0 = add_dat_q.size(); r0 = ret_cyc_q.size(); v0 = vld_n;
      job_tag = 2;
      drive_job(8'h10, 8'h04, 16'd6, 5, 0, s, d, ss, sb);
      n_cmp++;
      if (d !== s + 14) begin n_bad++; $display("FAIL bp_done_cyc: got %0d want 14", d - s); end
      n_cmp++;
      if (ss !== 5 || sb !== 0) begin n_bad++; $display("FAIL bp_stall_gating: got stalled %0d bad %0d want 5 0", ss, sb); end
      n_cmp++;
      if (vld_n - v0 !== 11 || ret_cyc_q.size() - r0 !== 6) begin
         n_bad++;
         $display("FAIL bp_out_cnt: got vld %0d ret %0d want 11 6", vld_n - v0, ret_cyc_q.size() - r0);
      end
      n_cmp++;
      if (add_dat_q.size() - d0 !== 6) begin n_bad++; $display("FAIL bp_add_cnt: got %0d want 6", add_dat_q.size() - d0); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (acc_cyc_q[a0+i] !== s + exp_acc[i] || add_cyc_q[d0+i] !== s + exp_add[i] || ret_cyc_q[r0+i] !== s + exp_ret[i]) begin
            n_bad++;
            $display("FAIL bp_timing%0d: got acc %0d add %0d ret %0d want %0d %0d %0d", i,
                     acc_cyc_q[a0+i] - s, add_cyc_q[d0+i] - s, ret_cyc_q[r0+i] - s, exp_acc[i], exp_add[i], exp_ret[i]);
         end
         n_cmp++;
         if (add_dat_q[d0+i] !== mkvec(2, i)) begin
            n_bad++;
            $display("FAIL bp_add_dat%0d: got %h want %h", i, add_dat_q[d0+i][31:0], mkvec(2, i)[31:0]);
         end
      end
`ifdef BIAS_ADD_CTRL_PERF_EN
      n_cmp++;
      if (stall_cnt !== 32'd5) begin n_bad++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); end
`endif
   endtask

   task automatic test_vec_zero();
      int s, d, ss, sb, a0, rd0, b0, dn0;
      a0 = acc_cyc_q.size(); rd0 = rd_n; b0 = busy_n; dn0 = done_q.size();
      job_tag = 3;
      drive_job(8'h20, 8'h04, 16'd0, 0, 0, s, d, ss, sb);
      n_cmp++;
      if (d !== s + 2) begin n_bad++; $display("FAIL vec0_done_cyc: got %0d want 2", d - s); end
      n_cmp++;
      if (acc_cyc_q.size() - a0 !== 0 || rd_n - rd0 !== 0) begin
         n_bad++;
         $display("FAIL vec0_reads: got acc %0d rd %0d want 0 0", acc_cyc_q.size() - a0, rd_n - rd0);
      end
      n_cmp++;
      if (busy_n - b0 !== 2 || done_q.size() - dn0 !== 1) begin
         n_bad++;
         $display("FAIL vec0_busy_done: got busy %0d done %0d want 2 1", busy_n - b0, done_q.size() - dn0);
      end
   endtask

   task automatic test_len_zero();
      int s, d, ss, sb, a0;
      a0 = acc_cyc_q.size();
      job_tag = 4;
      drive_job(8'h40, 8'h00, 16'd3, 0, 0, s, d, ss, sb);
      n_cmp++;
      if (d !== s + 6) begin n_bad++; $display("FAIL len0_done_cyc: got %0d want 6", d - s); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (acc_addr_q[a0+i] !== 9'h140) begin n_bad++; $display("FAIL len0_addr%0d: got %h want 140", i, acc_addr_q[a0+i]); end
      end
   endtask

   task automatic test_addr_wrap();
      int s, d, ss, sb, a0;
      logic [8:0] exp_a [4];
      exp_a = '{9'h1FE, 9'h1FF, 9'h100, 9'h1FE};
      a0 = acc_cyc_q.size();
      job_tag = 6;
      drive_job(8'hFE, 8'h03, 16'd4, 0, 0, s, d, ss, sb);
      n_cmp++;
      if (d !== s + 7) begin n_bad++; $display("FAIL wrap_done_cyc: got %0d want 7", d - s); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (acc_addr_q[a0+i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, acc_addr_q[a0+i], exp_a[i]); end
      end
   endtask

   task automatic test_illegal_start();
      test_basic(8, 2, "illegal_start");
   endtask

   task automatic test_reset_midjob();
      int dn0;
      dn0 = done_q.size();
      bus.i_cfg_base = 8'h30; bus.i_cfg_bias_len = 8'h02; bus.i_cfg_vec_num = 16'd6;
      bus.i_start = 1'b1; bus.i_out_rdy = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0; bus.i_npe_vld = 1'b1; bus.i_npe_dat = mkvec(7, 0);
      repeat (3) @(posedge clk);
      #3;
      n_cmp++;
      if ({bus.o_busy, bus.o_out_vld} !== 2'b11) begin n_bad++; $display("FAIL mid_prereq: got %b want 11", {bus.o_busy, bus.o_out_vld}); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.o_npe_rdy, bus.o_ram_rd_en, bus.o_add_en, bus.o_out_vld, bus.o_busy, bus.o_done} !== 6'b0) begin
         n_bad++;
         $display("FAIL mid_rst_ctrl: got %b want 000000", {bus.o_npe_rdy, bus.o_ram_rd_en, bus.o_add_en, bus.o_out_vld, bus.o_busy, bus.o_done});
      end
      n_cmp++;
      if (bus.o_ram_addr !== 8'h00 || bus.o_add_npe_dat !== 512'd0) begin
         n_bad++;
         $display("FAIL mid_rst_data: got addr %h dat_lo %h want 0", bus.o_ram_addr, bus.o_add_npe_dat[31:0]);
      end
      bus.i_npe_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (done_q.size() - dn0 !== 0 || bus.o_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_no_done: got done %0d busy %b want 0 0", done_q.size() - dn0, bus.o_busy);
      end
   endtask

   initial begin
      bus.i_start = 1'b0; bus.i_cfg_base = 8'h00; bus.i_cfg_bias_len = 8'h00;
      bus.i_cfg_vec_num = 16'd0; bus.i_npe_vld = 1'b0; bus.i_npe_dat = 512'd0;
      bus.i_out_rdy = 1'b1;
      test_reset();
      test_basic(1, 0, "basic");
      test_backpressure();
      test_vec_zero();
      test_len_zero();
      test_addr_wrap();
      test_illegal_start();
      test_reset_midjob();
      test_basic(5, 0, "recover");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
